// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and issues one instruction-memory
// fetch at a time over a req/ack handshake. Taken branches redirect the PC
// and raise a one-cycle flush; stall holds off new requests and halt parks
// the sequencer once the outstanding request has completed.
module pc_sequencer #(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int              INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  input  logic            halt,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc,
  output logic            flush,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_INC - {{(PC_W-1){1'b0}}, 1'b1});

  // Branch targets are forced onto an instruction boundary before use.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic            redir_pend_r, redir_pend_s;
  logic [PC_W-1:0] redir_pc_r, redir_pc_s;
  logic            fetch_valid_r, fetch_valid_s;
  logic [PC_W-1:0] fetch_pc_r, fetch_pc_s;
  logic            flush_r, flush_s;
  logic            imem_req_r;
  logic [PC_W-1:0] imem_addr_r;
  logic            halted_r;
  logic [PC_W-1:0] target_s;

  assign target_s    = align_pc(branch_target);
  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_pc    = fetch_pc_r;
  assign flush       = flush_r;
  assign halted      = halted_r;

  // Next-state, next-PC and pulse outputs; everything defaults to "hold".
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    redir_pend_s  = redir_pend_r;
    redir_pc_s    = redir_pc_r;
    fetch_valid_s = 1'b0;
    fetch_pc_s    = fetch_pc_r;
    flush_s       = 1'b0;
    case (state_r)
      IDLE, WAIT: begin
        // No request in flight, so a redirect lands in the PC directly.
        if (branch_taken) begin
          pc_s    = target_s;
          flush_s = 1'b1;
        end else begin
          pc_s    = pc_r;
        end
        if (halt) begin
          state_s = HALTED;
        end else if (stall) begin
          state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      ISSUE: begin
        if (imem_ack) begin
          // A fresh redirect beats an older pending one; either discards the fetch.
          if (branch_taken) begin
            pc_s         = target_s;
            flush_s      = 1'b1;
            redir_pend_s = 1'b0;
          end else if (redir_pend_r) begin
            pc_s         = redir_pc_r;
            redir_pend_s = 1'b0;
          end else begin
            fetch_valid_s = 1'b1;
            fetch_pc_s    = pc_r;
            pc_s          = pc_r + PC_INC;
          end
          if (halt) begin
            state_s = HALTED;
          end else if (stall) begin
            state_s = WAIT;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          // Request must stay stable, so remember the redirect until ack.
          if (branch_taken) begin
            redir_pend_s = 1'b1;
            redir_pc_s   = target_s;
            flush_s      = 1'b1;
          end else begin
            redir_pend_s = redir_pend_r;
          end
          state_s = ISSUE;
        end
      end
      HALTED: begin
        state_s = HALTED;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC and registered outputs; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      redir_pend_r  <= 1'b0;
      redir_pc_r    <= {PC_W{1'b0}};
      fetch_valid_r <= 1'b0;
      fetch_pc_r    <= {PC_W{1'b0}};
      flush_r       <= 1'b0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= RESET_PC;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      redir_pend_r  <= redir_pend_s;
      redir_pc_r    <= redir_pc_s;
      fetch_valid_r <= fetch_valid_s;
      fetch_pc_r    <= fetch_pc_s;
      flush_r       <= flush_s;
      imem_req_r    <= (state_s == ISSUE);
      imem_addr_r   <= pc_s;
      halted_r      <= (state_s == HALTED);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a 32-bit instance exercises fetch,
// stall, redirect and halt behaviour; an 8-bit instance checks PC wrap.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        halted;

  logic        bt8;
  logic [7:0]  tgt8;
  logic        stall8;
  logic        halt8;
  logic        req8;
  logic [7:0]  addr8;
  logic        ack8;
  logic        fv8;
  logic [7:0]  fpc8;
  logic        flush8;
  logic        halted8;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .flush(flush), .halted(halted)
  );

  pc_sequencer #(.PC_W(8), .RESET_PC(8'hF8), .INSTR_BYTES(4)) dut8 (
    .clk(clk), .rst(rst), .branch_taken(bt8), .branch_target(tgt8),
    .stall(stall8), .halt(halt8), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(ack8), .fetch_valid(fv8), .fetch_pc(fpc8),
    .flush(flush8), .halted(halted8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every fetch_valid must match the oldest expected fetch PC.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL fetch_sb: unexpected fetch_valid, fetch_pc=%h, none expected", fetch_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (fetch_pc !== exp_pc) begin
          n_err++;
          $display("FAIL fetch_sb: fetch_pc=%h expected %h", fetch_pc, exp_pc);
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h55;
    stall = 1'b1; halt = 1'b1; imem_ack = 1'b1;
    tick();
    n_vec++;
    if ({imem_req, fetch_valid, flush, halted} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: req/fv/flush/halted=%b expected 0000", {imem_req, fetch_valid, flush, halted});
    end
    n_vec++;
    if (imem_addr !== 32'h0 || fetch_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_addr: addr=%h fetch_pc=%h expected 0/0", imem_addr, fetch_pc);
    end
    n_vec++;
    if (addr8 !== 8'hF8 || req8 !== 1'b0) begin
      n_err++; $display("FAIL reset_pc8: addr8=%h req8=%b expected f8/0", addr8, req8);
    end
    branch_taken = 1'b0; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL reset_first_req: req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        n_err++; $display("FAIL seq_addr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, 32'(i * 4));
      end
      imem_ack = 1'b1;
      exp_q.push_back(32'(i * 4));
      tick();
    end
    imem_ack = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h10) begin
      n_err++; $display("FAIL seq_next: addr=%h expected 10", imem_addr);
    end
  endtask

  task automatic test_stall_hold;
    logic [2:0] pat;
    pat = 3'b101;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      stall = pat[i];
      tick();
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_hold: req=%b addr=%h fv=%b expected 1/0/0", imem_req, imem_addr, fetch_valid);
      end
    end
    stall = 1'b1; imem_ack = 1'b1; exp_q.push_back(32'h0);
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_wait: req=%b expected 0", imem_req);
    end
    tick();
    stall = 1'b0;
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_err++; $display("FAIL stall_resume: req=%b addr=%h expected 1/4", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_pending;
    imem_ack = 1'b1; exp_q.push_back(32'h4);
    tick();
    imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    n_vec++;
    if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++; $display("FAIL redir_pend_flush: flush=%b req=%b addr=%h expected 1/1/8", flush, imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (flush !== 1'b0 || imem_addr !== 32'h8) begin
      n_err++; $display("FAIL redir_pend_hold: flush=%b addr=%h expected 0/8", flush, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL redir_pend_ack: fv=%b req=%b addr=%h expected 0/1/100", fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_multi_redirect;
    branch_taken = 1'b1; branch_target = 32'h180;
    tick();
    n_vec++;
    if (flush !== 1'b1) begin
      n_err++; $display("FAIL multi_flush1: flush=%b expected 1", flush);
    end
    branch_target = 32'h1C0;
    tick();
    branch_taken = 1'b0;
    n_vec++;
    if (flush !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL multi_flush2: flush=%b addr=%h expected 1/100", flush, imem_addr);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h1C0 || flush !== 1'b0) begin
      n_err++; $display("FAIL multi_last_wins: addr=%h flush=%b expected 1c0/0", imem_addr, flush);
    end
  endtask

  task automatic test_redirect_with_ack;
    imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    n_vec++;
    if (flush !== 1'b1 || fetch_valid !== 1'b0 || imem_addr !== 32'h20) begin
      n_err++; $display("FAIL ack_redir1: flush=%b fv=%b addr=%h expected 1/0/20", flush, fetch_valid, imem_addr);
    end
    branch_target = 32'h40;
    tick();
    n_vec++;
    if (flush !== 1'b1 || fetch_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_err++; $display("FAIL ack_redir2: flush=%b fv=%b addr=%h expected 1/0/40", flush, fetch_valid, imem_addr);
    end
    branch_taken = 1'b0; exp_q.push_back(32'h40);
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (flush !== 1'b0 || imem_addr !== 32'h44) begin
      n_err++; $display("FAIL ack_redir_after: flush=%b addr=%h expected 0/44", flush, imem_addr);
    end
  endtask

  task automatic test_redirect_wait;
    imem_ack = 1'b1; stall = 1'b1; exp_q.push_back(32'h44);
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL wait_enter: req=%b expected 0", imem_req);
    end
    branch_taken = 1'b1; branch_target = 32'h20F; stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    n_vec++;
    if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h20C) begin
      n_err++; $display("FAIL wait_redir: flush=%b req=%b addr=%h expected 1/1/20c", flush, imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (flush !== 1'b0 || imem_addr !== 32'h20C) begin
      n_err++; $display("FAIL wait_redir_hold: flush=%b addr=%h expected 0/20c", flush, imem_addr);
    end
  endtask

  task automatic test_halt;
    halt = 1'b1;
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'h20C) begin
      n_err++; $display("FAIL halt_outstanding: req=%b halted=%b addr=%h expected 1/0/20c", imem_req, halted, imem_addr);
    end
    branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_taken = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h300 || fetch_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_pend_redir: halted=%b req=%b addr=%h fv=%b expected 1/0/300/0", halted, imem_req, imem_addr, fetch_valid);
    end
    halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h400;
    tick();
    branch_taken = 1'b0;
    n_vec++;
    if (flush !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'h300) begin
      n_err++; $display("FAIL halted_ignore: flush=%b halted=%b addr=%h expected 0/1/300", flush, halted, imem_addr);
    end
    apply_reset();
    halt = 1'b1; imem_ack = 1'b1; exp_q.push_back(32'h0);
    tick();
    imem_ack = 1'b0; halt = 1'b0;
    n_vec++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL halt_deliver: halted=%b req=%b expected 1/0", halted, imem_req);
    end
  endtask

  task automatic test_reset_mid_request;
    apply_reset();
    imem_ack = 1'b1; exp_q.push_back(32'h0);
    tick();
    imem_ack = 1'b0;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || halted !== 1'b0) begin
      n_err++; $display("FAIL restart: req=%b addr=%h halted=%b expected 1/4/0", imem_req, imem_addr, halted);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
      n_err++; $display("FAIL midreq_reset: req=%b addr=%h halted=%b expected 0/0/0", imem_req, imem_addr, halted);
    end
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL post_reset_req: req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    n_vec++;
    if (req8 !== 1'b1 || addr8 !== 8'hF8) begin
      n_err++; $display("FAIL wrap_start: req8=%b addr8=%h expected 1/f8", req8, addr8);
    end
    ack8 = 1'b1;
    tick();
    n_vec++;
    if (fv8 !== 1'b1 || fpc8 !== 8'hF8 || addr8 !== 8'hFC) begin
      n_err++; $display("FAIL wrap_fc: fv8=%b fpc8=%h addr8=%h expected 1/f8/fc", fv8, fpc8, addr8);
    end
    tick();
    ack8 = 1'b0;
    n_vec++;
    if (fv8 !== 1'b1 || fpc8 !== 8'hFC || addr8 !== 8'h00) begin
      n_err++; $display("FAIL wrap_00: fv8=%b fpc8=%h addr8=%h expected 1/fc/00", fv8, fpc8, addr8);
    end
    tick();
    n_vec++;
    if (fv8 !== 1'b0 || req8 !== 1'b1 || addr8 !== 8'h00) begin
      n_err++; $display("FAIL wrap_hold: fv8=%b req8=%b addr8=%h expected 0/1/00", fv8, req8, addr8);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0; halt = 1'b0; imem_ack = 1'b0;
    bt8 = 1'b0; tgt8 = 8'h00; stall8 = 1'b0; halt8 = 1'b0; ack8 = 1'b0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_pending();
    test_multi_redirect();
    test_redirect_with_ack();
    test_redirect_wait();
    test_halt();
    test_reset_mid_request();
    test_wrap();
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL fetch_sb_drain: %0d expected fetches never delivered, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
